// File: rtl/hex_disp_pkg.sv
// Shared types and helpers for the two-digit display scheduler.
package hex_disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MSG   = 2'd1,
    BLANK = 2'd2
  } state_e;

  localparam logic [7:0] DISP_MAX = 8'd99;

  typedef struct packed {
    logic [7:0] value;
    logic       err;
  } msg_t;

  function automatic int unsigned cycles_per_ms(input int unsigned clk_hz);
    return clk_hz / 1000;
  endfunction

  function automatic logic [7:0] clamp99(input logic [7:0] v);
    return (v > DISP_MAX) ? DISP_MAX : v;
  endfunction

endpackage

// File: rtl/hex_disp_sched_ms_tick_gen.sv
// Millisecond prescaler: counts 0..CLK_HZ/1000-1, pulses tick_o at the top,
// and restarts from 0 whenever clr_i is high.
module ms_tick_gen
  import hex_disp_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CPM = cycles_per_ms(CLK_HZ);
  localparam int unsigned PW  = $clog2(CPM);

  logic [PW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == PW'(CPM - 1));

  always_comb begin
    cnt_d = cnt_q + PW'(1);
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hex_disp_sched.sv
// Display scheduler: arbitrates live value vs timed messages with a depth-1
// pending slot. Define HEX_BLINK_EN to blink error messages.
module hex_disp_sched
  import hex_disp_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned HOLD_MS  = 1000,
  parameter int unsigned BLANK_MS = 100,
  parameter int unsigned BLINK_MS = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] live_value,
  input  logic       live_valid,
  input  logic       msg_req,
  input  logic [7:0] msg_value,
  input  logic       msg_err,
  output logic       msg_busy,
  output logic       msg_drop,
  output logic [7:0] disp_value,
  output logic       disp_error,
  output logic       disp_none
);

  localparam int unsigned MS_MAX = (HOLD_MS > BLANK_MS) ? HOLD_MS : BLANK_MS;
  localparam int unsigned MSW    = $clog2(MS_MAX + 1);

  state_e         state_q, state_d;
  msg_t           cur_q, cur_d;
  msg_t           pend_q, pend_d;
  msg_t           req_msg;
  logic           pend_vld_q, pend_vld_d;
  logic [MSW-1:0] ms_q, ms_d;
  logic           restart, clr, tick;
  logic           hold_done, blank_done;
  logic           phase;

  logic [7:0]     disp_value_q, disp_value_d;
  logic           disp_error_q, disp_error_d;
  logic           disp_none_q, disp_none_d;
  logic           busy_q, busy_d;
  logic           drop_q, drop_d;

  ms_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clr),
    .tick_o(tick)
  );

  assign req_msg.value = clamp99(msg_value);
  assign req_msg.err   = msg_err;
  assign hold_done     = tick && (ms_q == MSW'(HOLD_MS - 1));
  assign blank_done    = tick && (ms_q == MSW'(BLANK_MS - 1));

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    restart    = 1'b0;
    drop_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (msg_req) begin
          state_d = MSG;
          cur_d   = req_msg;
        end else if (pend_vld_q) begin
          state_d    = MSG;
          cur_d      = pend_q;
          pend_vld_d = 1'b0;
        end
      end
      MSG: begin
        if (msg_req && msg_err && !cur_q.err) begin
          cur_d   = req_msg;
          restart = 1'b1;
        end else begin
          if (msg_req) begin
            pend_d     = req_msg;
            pend_vld_d = 1'b1;
            drop_d     = pend_vld_q;
          end
          if (hold_done) begin
            state_d = pend_vld_d ? BLANK : IDLE;
          end
        end
      end
      BLANK: begin
        // A request landing on the last blank cycle overwrites the slot first,
        // so it is the one promoted into MSG.
        if (msg_req) begin
          pend_d     = req_msg;
          pend_vld_d = 1'b1;
          drop_d     = pend_vld_q;
        end
        if (blank_done) begin
          state_d    = MSG;
          cur_d      = pend_d;
          pend_vld_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign clr = restart || (state_d != state_q);

  always_comb begin
    ms_d = ms_q;
    if (clr || (state_q == IDLE)) begin
      ms_d = '0;
    end else if (tick) begin
      ms_d = ms_q + MSW'(1);
    end
  end

`ifdef HEX_BLINK_EN
  localparam int unsigned BLW = $clog2(BLINK_MS + 1);

  logic [BLW-1:0] bl_q, bl_d;
  logic           blink_q, blink_d;

  always_comb begin
    bl_d    = bl_q;
    blink_d = blink_q;
    if (clr) begin
      bl_d    = '0;
      blink_d = 1'b0;
    end else if (tick) begin
      if (bl_q == BLW'(BLINK_MS - 1)) begin
        bl_d    = '0;
        blink_d = !blink_q;
      end else begin
        bl_d = bl_q + BLW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bl_q    <= '0;
      blink_q <= 1'b0;
    end else begin
      bl_q    <= bl_d;
      blink_q <= blink_d;
    end
  end

  assign phase = blink_d;
`else
  assign phase = 1'b0;
`endif

  // Outputs are decoded from next-state so the display moves on the same edge.
  always_comb begin
    disp_value_d = '0;
    disp_error_d = 1'b0;
    disp_none_d  = 1'b1;
    unique case (state_d)
      IDLE: begin
        disp_value_d = clamp99(live_value);
        disp_none_d  = !live_valid;
      end
      MSG: begin
        disp_value_d = cur_d.err ? 8'd0 : cur_d.value;
        disp_error_d = cur_d.err;
        disp_none_d  = cur_d.err && phase;
      end
      default: begin
        disp_none_d = 1'b1;
      end
    endcase
    busy_d = (state_d != IDLE) || pend_vld_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cur_q        <= '0;
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      ms_q         <= '0;
      disp_value_q <= '0;
      disp_error_q <= 1'b0;
      disp_none_q  <= 1'b1;
      busy_q       <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      ms_q         <= ms_d;
      disp_value_q <= disp_value_d;
      disp_error_q <= disp_error_d;
      disp_none_q  <= disp_none_d;
      busy_q       <= busy_d;
      drop_q       <= drop_d;
    end
  end

  assign disp_value = disp_value_q;
  assign disp_error = disp_error_q;
  assign disp_none  = disp_none_q;
  assign msg_busy   = busy_q;
  assign msg_drop   = drop_q;

endmodule

// File: tb/tb_hex_disp_sched.sv
// Bench for hex_disp_sched: clamp table, hand-written timing sequences and a
// randomized run against a cycle-countdown reference model.
module tb_hex_disp_sched;

  localparam int unsigned CLK_HZ   = 4000;
  localparam int unsigned HOLD_MS  = 3;
  localparam int unsigned BLANK_MS = 1;
  localparam int unsigned BLINK_MS = 1;
  localparam int CPM = CLK_HZ / 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] live_value = '0;
  logic       live_valid = 1'b0;
  logic       msg_req = 1'b0;
  logic [7:0] msg_value = '0;
  logic       msg_err = 1'b0;
  logic       msg_busy, msg_drop, disp_error, disp_none;
  logic [7:0] disp_value;

  hex_disp_sched #(
    .CLK_HZ  (CLK_HZ),
    .HOLD_MS (HOLD_MS),
    .BLANK_MS(BLANK_MS),
    .BLINK_MS(BLINK_MS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .live_value(live_value),
    .live_valid(live_valid),
    .msg_req   (msg_req),
    .msg_value (msg_value),
    .msg_err   (msg_err),
    .msg_busy  (msg_busy),
    .msg_drop  (msg_drop),
    .disp_value(disp_value),
    .disp_error(disp_error),
    .disp_none (disp_none)
  );

  always #5 clk = ~clk;

  int n_tot = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clampv(input int v);
    return (v > 99) ? 99 : v;
  endfunction

  // Reference model: mode 0=live, 1=message, 2=blank; durations as cycle countdowns.
  typedef struct {int v; bit e;} rq_t;
  rq_t m_pend[$];
  int  m_mode = 0, m_left = 0, m_age = 0, m_cval = 0;
  bit  m_cerr = 1'b0;
  int  e_val = 0;
  bit  e_err = 1'b0, e_none = 1'b1, e_busy = 1'b0, e_drop = 1'b0;

  always @(posedge clk) begin : model
    bit   enter;
    rq_t  nw, nxt;
    if (rst) begin
      m_mode = 0;
      m_pend.delete();
      e_val = 0; e_err = 1'b0; e_none = 1'b1; e_busy = 1'b0; e_drop = 1'b0;
    end else begin
      enter = 1'b0;
      nw.v = clampv(int'(msg_value));
      nw.e = msg_err;
      nxt = nw;
      e_drop = 1'b0;
      case (m_mode)
        0: begin
          if (msg_req) begin nxt = nw; enter = 1'b1; end
          else if (m_pend.size() > 0) begin nxt = m_pend.pop_front(); enter = 1'b1; end
        end
        1: begin
          if (msg_req && msg_err && !m_cerr) begin
            nxt = nw; enter = 1'b1;
          end else begin
            if (msg_req) begin
              if (m_pend.size() > 0) begin e_drop = 1'b1; m_pend.delete(); end
              m_pend.push_back(nw);
            end
            m_left--;
            if (m_left == 0) begin
              if (m_pend.size() > 0) begin m_mode = 2; m_left = BLANK_MS * CPM; end
              else m_mode = 0;
            end
          end
        end
        default: begin
          if (msg_req) begin
            if (m_pend.size() > 0) begin e_drop = 1'b1; m_pend.delete(); end
            m_pend.push_back(nw);
          end
          m_left--;
          if (m_left == 0) begin nxt = m_pend.pop_front(); enter = 1'b1; end
        end
      endcase
      if (enter) begin
        m_mode = 1; m_left = HOLD_MS * CPM; m_cval = nxt.v; m_cerr = nxt.e; m_age = 0;
      end else begin
        m_age++;
      end
      case (m_mode)
        0: begin e_val = clampv(int'(live_value)); e_err = 1'b0; e_none = !live_valid; end
        1: begin
          e_val = m_cerr ? 0 : m_cval;
          e_err = m_cerr;
`ifdef HEX_BLINK_EN
          e_none = m_cerr && (((m_age / (BLINK_MS * CPM)) % 2) == 1);
`else
          e_none = 1'b0;
`endif
        end
        default: begin e_val = 0; e_err = 1'b0; e_none = 1'b1; end
      endcase
      e_busy = (m_mode != 0) || (m_pend.size() > 0);
    end
    #1;
    if (chk_en) begin
      if (m_mode != 2) chk("model disp_value", disp_value, e_val);
      chk("model disp_error", disp_error, e_err);
      chk("model disp_none", disp_none, e_none);
      chk("model msg_busy", msg_busy, e_busy);
      chk("model msg_drop", msg_drop, e_drop);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int v, input bit e);
    msg_value = 8'(v);
    msg_err   = e;
    msg_req   = 1'b1;
    step();
    msg_req   = 1'b0;
    msg_err   = 1'b0;
  endtask

  // val < 0 means the digit value is not checked (blank gap)
  task automatic expect_for(input int n, input int val, input bit err, input bit none,
                            input bit busy, input string nm);
    for (int i = 0; i < n; i++) begin
      if (val >= 0) chk({nm, " value"}, disp_value, val);
      chk({nm, " error"}, disp_error, err);
      chk({nm, " none"}, disp_none, none);
      chk({nm, " busy"}, msg_busy, busy);
      chk({nm, " drop"}, msg_drop, 0);
      step();
    end
  endtask

  task automatic chk_idle(input int val, input string nm);
    chk({nm, " value"}, disp_value, val);
    chk({nm, " none"}, disp_none, 0);
    chk({nm, " error"}, disp_error, 0);
    chk({nm, " busy"}, msg_busy, 0);
  endtask

  typedef struct {
    bit         lv;
    logic [7:0] val;
    int         exp_val;
    bit         exp_none;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{1'b1, 8'd0,   0,  1'b0};
    tbl[1] = '{1'b1, 8'd57,  57, 1'b0};
    tbl[2] = '{1'b1, 8'd98,  98, 1'b0};
    tbl[3] = '{1'b1, 8'd99,  99, 1'b0};
    tbl[4] = '{1'b1, 8'd100, 99, 1'b0};
    tbl[5] = '{1'b1, 8'd200, 99, 1'b0};
    tbl[6] = '{1'b1, 8'd255, 99, 1'b0};
    tbl[7] = '{1'b0, 8'd33,  33, 1'b1};

    rst = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    chk("reset value", disp_value, 0);
    chk("reset error", disp_error, 0);
    chk("reset none", disp_none, 1);
    chk("reset busy", msg_busy, 0);
    chk("reset drop", msg_drop, 0);
    rst = 1'b0;

    // Live view and clamp boundaries
    for (int i = 0; i < 8; i++) begin
      live_valid = tbl[i].lv;
      live_value = tbl[i].val;
      step();
      chk("table value", disp_value, tbl[i].exp_val);
      chk("table none", disp_none, tbl[i].exp_none);
      chk("table error", disp_error, 0);
    end

    // Single message, exact hold length
    live_valid = 1'b1;
    live_value = 8'd57;
    step();
    pulse(42, 1'b0);
    expect_for(12, 42, 1'b0, 1'b0, 1'b1, "hold42");
    chk_idle(57, "after42");

    // Back-to-back: 7, blank, 8
    pulse(7, 1'b0);
    expect_for(3, 7, 1'b0, 1'b0, 1'b1, "msg7a");
    pulse(8, 1'b0);
    expect_for(8, 7, 1'b0, 1'b0, 1'b1, "msg7b");
    expect_for(4, -1, 1'b0, 1'b1, 1'b1, "blank78");
    expect_for(12, 8, 1'b0, 1'b0, 1'b1, "msg8");
    chk_idle(57, "after8");

    // Pending overwrite: 5, blank, 9 with one drop pulse
    pulse(5, 1'b0);
    expect_for(2, 5, 1'b0, 1'b0, 1'b1, "msg5a");
    pulse(6, 1'b0);
    chk("drop after 6", msg_drop, 0);
    pulse(9, 1'b0);
    chk("drop after 9", msg_drop, 1);
    chk("msg5 during drop", disp_value, 5);
    step();
    expect_for(7, 5, 1'b0, 1'b0, 1'b1, "msg5b");
    expect_for(4, -1, 1'b0, 1'b1, 1'b1, "blank59");
    expect_for(12, 9, 1'b0, 1'b0, 1'b1, "msg9");
    chk_idle(57, "after9");

    // Error preemption restarts the hold
    pulse(33, 1'b0);
    expect_for(5, 33, 1'b0, 1'b0, 1'b1, "msg33");
    pulse(77, 1'b1);
`ifdef HEX_BLINK_EN
    expect_for(4, 0, 1'b1, 1'b0, 1'b1, "errA");
    expect_for(4, 0, 1'b1, 1'b1, 1'b1, "errB");
    expect_for(4, 0, 1'b1, 1'b0, 1'b1, "errC");
`else
    expect_for(12, 0, 1'b1, 1'b0, 1'b1, "err");
`endif
    chk_idle(57, "after err");

    // Reset mid-message discards the pending slot
    live_value = 8'd64;
    pulse(11, 1'b0);
    step();
    step();
    pulse(22, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst none", disp_none, 1);
    chk("midrst busy", msg_busy, 0);
    chk("midrst value", disp_value, 0);
    step();
    expect_for(20, 64, 1'b0, 1'b0, 1'b0, "postrst");

    // Randomized run checked by the model
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 299) == 0);
      live_valid = ($urandom_range(0, 7) != 0);
      live_value = 8'($urandom);
      msg_req    = ($urandom_range(0, 5) == 0);
      msg_value  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(95, 105)) : 8'($urandom);
      msg_err    = ($urandom_range(0, 3) == 0);
      step();
    end
    msg_req = 1'b0;
    step();
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
